// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the RV32I multicycle control FSM and its datapath.
// master = control FSM (drives selects/enables), slave = datapath (drives instruction fields and zero).
interface multicycle_ctrl_fsm_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       pc_write;
  logic       ir_write;
  logic       adr_src;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [3:0] alu_control;

  modport master (
    input  opcode, funct3, funct7_5, zero,
    output pc_write, ir_write, adr_src, mem_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_control
  );

  modport slave (
    output opcode, funct3, funct7_5, zero,
    input  pc_write, ir_write, adr_src, mem_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_control
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the RV32I multicycle datapath; ALU_SLT_EN adds set-less-than (alu_control 0111).
//
// state    | meaning
// FETCH    | read instr at PC, PC <= PC+4
// DECODE   | read regs, ALUOut <= branch target
// MEMADR   | ALUOut <= rs1 + imm
// MEMREAD  | read data memory at ALUOut
// MEMWB    | rd <= memory data
// MEMWRITE | write rs2 to memory at ALUOut
// EXECUTER | ALUOut <= rs1 op rs2
// ALUWB    | rd <= ALUOut
// EXECUTEI | ALUOut <= rs1 op imm
// JAL      | PC <= target, ALUOut <= oldPC+4
// BEQ      | compare rs1/rs2, PC <= target if equal
module multicycle_ctrl_fsm #(
  parameter int STATE_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_ctrl_fsm_if.master bus,
  output logic [STATE_W-1:0]   state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
  } ctl_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  state_t cur;
  state_t nxt;
  ctl_t   ctl_q;
  logic   in_exec;
  logic [3:0] funct_alu;

  function automatic ctl_t moore_out(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write = 1'b1; c.alu_src_b = 2'b10; c.alu_control = ALU_ADD;
        c.result_src = 2'b10; c.pc_write = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; c.alu_control = ALU_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_control = ALU_ADD;
      end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = 2'b01; c.reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src = 1'b1; c.mem_write = 1'b1;
      end
      S_EXECUTER: c.alu_src_a = 2'b10;
      S_EXECUTEI: begin
        c.alu_src_a = 2'b10; c.alu_src_b = 2'b01;
      end
      S_ALUWB:    c.reg_write = 1'b1;
      // BEQ pc_write comes from the zero flag at the output, not from here
      S_BEQ: begin
        c.alu_src_a = 2'b10; c.alu_control = ALU_SUB;
      end
      S_JAL: begin
        c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.alu_control = ALU_ADD;
        c.pc_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH: nxt = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          7'b0000011, 7'b0100011: nxt = S_MEMADR;
          7'b0110011:             nxt = S_EXECUTER;
          7'b0010011:             nxt = S_EXECUTEI;
          7'b1100011:             nxt = S_BEQ;
          7'b1101111:             nxt = S_JAL;
          default:                nxt = S_FETCH;
        endcase
      end
      S_MEMADR:   nxt = (bus.opcode == 7'b0000011) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  nxt = S_MEMWB;
      S_EXECUTER: nxt = S_ALUWB;
      S_EXECUTEI: nxt = S_ALUWB;
      S_JAL:      nxt = S_ALUWB;
      default:    nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur   <= S_FETCH;
      ctl_q <= moore_out(S_FETCH);
    end else begin
      cur   <= nxt;
      ctl_q <= moore_out(nxt);
    end
  end

  always_comb begin
    funct_alu = ALU_ADD;
    case (bus.funct3)
      3'b000: funct_alu = (cur == S_EXECUTER && bus.funct7_5) ? ALU_SUB : ALU_ADD;
      3'b111: funct_alu = ALU_AND;
      3'b110: funct_alu = ALU_OR;
`ifdef ALU_SLT_EN
      3'b010: funct_alu = ALU_SLT;
`else
      3'b010: funct_alu = ALU_ADD;
`endif
      default: funct_alu = ALU_ADD;
    endcase
  end

  assign in_exec = (cur == S_EXECUTER) || (cur == S_EXECUTEI);

  // write enables are gated by rst_n so nothing writes while reset is held
  assign bus.pc_write    = rst_n & (ctl_q.pc_write | ((cur == S_BEQ) & bus.zero));
  assign bus.ir_write    = rst_n & ctl_q.ir_write;
  assign bus.mem_write   = rst_n & ctl_q.mem_write;
  assign bus.reg_write   = rst_n & ctl_q.reg_write;
  assign bus.adr_src     = ctl_q.adr_src;
  assign bus.result_src  = ctl_q.result_src;
  assign bus.alu_src_a   = ctl_q.alu_src_a;
  assign bus.alu_src_b   = ctl_q.alu_src_b;
  assign bus.alu_control = in_exec ? funct_alu : ctl_q.alu_control;

  always_comb begin
    case (bus.opcode)
      7'b0100011: bus.imm_src = 2'b01;
      7'b1100011: bus.imm_src = 2'b10;
      7'b1101111: bus.imm_src = 2'b11;
      default:    bus.imm_src = 2'b00;
    endcase
  end

  assign state = STATE_W'(cur);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm; honours ALU_SLT_EN for the funct3 010 expectation.
module tb_multicycle_ctrl_fsm;

  logic       clk;
  logic       rst_n;
  logic [3:0] state;
  int         n_vec;
  int         n_err;

  multicycle_ctrl_fsm_if bus();

  multicycle_ctrl_fsm #(.STATE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master),
    .state (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ALU_SLT_EN
  localparam logic [3:0] SLT_EXP = 4'b0111;
`else
  localparam logic [3:0] SLT_EXP = 4'b0010;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] we_bits();
    return {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write};
  endfunction

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
    bus.opcode = op; bus.funct3 = f3; bus.funct7_5 = f7; bus.zero = z;
  endtask

  // R/I-type from FETCH: DECODE, execute state, ALUWB, FETCH
  task automatic exec_op(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic f7, input logic [3:0] exp_state, input logic [3:0] exp_alu);
    set_instr(op, f3, f7, 1'b0);
    tick(); chk({tag, "_dec"}, 32'(state), 32'd1);
    tick(); chk({tag, "_exst"}, 32'(state), 32'(exp_state));
    chk({tag, "_alu"}, 32'(bus.alu_control), 32'(exp_alu));
    chk({tag, "_exwe"}, 32'(we_bits()), 32'd0);
    tick(); chk({tag, "_wb"}, 32'(state), 32'd7);
    chk({tag, "_wbwe"}, 32'({bus.reg_write, bus.result_src}), 32'b100);
    tick(); chk({tag, "_end"}, 32'(state), 32'd0);
  endtask

  task automatic beq_op(input string tag, input logic z);
    set_instr(7'b1100011, 3'b000, 1'b0, z);
    tick(); chk({tag, "_dec"}, 32'(state), 32'd1);
    chk({tag, "_imm"}, 32'(bus.imm_src), 32'd2);
    tick(); chk({tag, "_st"}, 32'(state), 32'd10);
    chk({tag, "_pcw"}, 32'(bus.pc_write), 32'(z));
    chk({tag, "_alu"}, 32'(bus.alu_control), 32'b0110);
    tick(); chk({tag, "_end"}, 32'(state), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_we", 32'(we_bits()), 32'd0);
    chk("rst_alu", 32'(bus.alu_control), 32'b0010);
    chk("rst_rsrc", 32'(bus.result_src), 32'b10);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("fetch_we", 32'(we_bits()), 32'b1100);
    chk("fetch_alu", 32'(bus.alu_control), 32'b0010);
    chk("fetch_srcb", 32'(bus.alu_src_b), 32'b10);

    // lw: 0,1,2,3,4,0
    tick(); chk("lw_dec", 32'(state), 32'd1);
    chk("lw_imm", 32'(bus.imm_src), 32'd0);
    chk("lw_dec_srca", 32'(bus.alu_src_a), 32'b01);
    chk("lw_dec_we", 32'(we_bits()), 32'd0);
    tick(); chk("lw_adr", 32'(state), 32'd2);
    chk("lw_adr_we", 32'(we_bits()), 32'd0);
    tick(); chk("lw_rd", 32'(state), 32'd3);
    chk("lw_rd_adrsrc", 32'(bus.adr_src), 32'd1);
    chk("lw_rd_we", 32'(we_bits()), 32'd0);
    tick(); chk("lw_wb", 32'(state), 32'd4);
    chk("lw_wb_we", 32'(we_bits()), 32'b0010);
    chk("lw_wb_rsrc", 32'(bus.result_src), 32'b01);
    tick(); chk("lw_end", 32'(state), 32'd0);

    exec_op("r_sub", 7'b0110011, 3'b000, 1'b1, 4'd6, 4'b0110);
    exec_op("r_add", 7'b0110011, 3'b000, 1'b0, 4'd6, 4'b0010);
    exec_op("r_and", 7'b0110011, 3'b111, 1'b1, 4'd6, 4'b0000);
    exec_op("r_or",  7'b0110011, 3'b110, 1'b0, 4'd6, 4'b0001);
    exec_op("i_add", 7'b0010011, 3'b000, 1'b1, 4'd8, 4'b0010);
    exec_op("r_slt", 7'b0110011, 3'b010, 1'b0, 4'd6, SLT_EXP);
    exec_op("i_slt", 7'b0010011, 3'b010, 1'b0, 4'd8, SLT_EXP);
    exec_op("r_xor", 7'b0110011, 3'b100, 1'b0, 4'd6, 4'b0010);

    beq_op("beq_t", 1'b1);
    beq_op("beq_f", 1'b0);

    // sw: 0,1,2,5,0
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    tick(); chk("sw_dec", 32'(state), 32'd1);
    chk("sw_imm", 32'(bus.imm_src), 32'd1);
    tick(); chk("sw_adr", 32'(state), 32'd2);
    chk("sw_adr_we", 32'(we_bits()), 32'd0);
    tick(); chk("sw_wr", 32'(state), 32'd5);
    chk("sw_wr_we", 32'(we_bits()), 32'b0001);
    chk("sw_wr_adrsrc", 32'(bus.adr_src), 32'd1);
    tick(); chk("sw_end", 32'(state), 32'd0);

    // jal: 0,1,9,7,0
    set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
    tick(); chk("jal_dec", 32'(state), 32'd1);
    chk("jal_imm", 32'(bus.imm_src), 32'd3);
    tick(); chk("jal_st", 32'(state), 32'd9);
    chk("jal_we", 32'(we_bits()), 32'b1000);
    chk("jal_src", 32'({bus.alu_src_a, bus.alu_src_b}), 32'b0110);
    tick(); chk("jal_wb", 32'(state), 32'd7);
    tick(); chk("jal_end", 32'(state), 32'd0);

    // illegal opcode: 0,1,0
    set_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
    tick(); chk("ill_dec", 32'(state), 32'd1);
    chk("ill_we", 32'(we_bits()), 32'd0);
    tick(); chk("ill_end", 32'(state), 32'd0);

    // reset in MEMREAD
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk("rst3_pre", 32'(state), 32'd3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst3_state", 32'(state), 32'd0);
    chk("rst3_we", 32'(we_bits()), 32'd0);
    tick();
    chk("rst3_hold", 32'(state), 32'd0);
    chk("rst3_hold_we", 32'(we_bits()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); chk("rst3_resume", 32'(state), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Main control FSM for the RV32I multicycle datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback cycles.
- Drives datapath mux selects and write enables.
- Generates the 4-bit control code consumed by the ALU: AND 0000, OR 0001, ADD 0010, SUB 0110.

Parameters:
- STATE_W, 4, width of the state register and of the debug state output.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7_5  in  1  instr[30]
- zero  in  1  ALU zero flag
- pc_write  out  1  PC load enable
- ir_write  out  1  instruction register load enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  data memory write enable
- reg_write  out  1  register file write enable
- result_src  out  2  result select: 00 ALUOut, 01 memory data, 10 ALU result
- alu_src_a  out  2  ALU A select: 00 PC, 01 oldPC, 10 rs1
- alu_src_b  out  2  ALU B select: 00 rs2, 01 immediate, 10 constant 4
- imm_src  out  2  immediate format: 00 I, 01 S, 10 B, 11 J
- alu_control  out  4  ALU operation code
- state  out  STATE_W  current state, for debug

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst_n low forces state to FETCH (0) asynchronously.
  - While rst_n is low, pc_write, ir_write, reg_write and mem_write are forced to 0. All other outputs take their FETCH values.
  - On the first rising clk edge after rst_n rises, FETCH executes normally.
  - Reset asserted mid-instruction aborts the instruction. No partial write occurs after reset asserts.
- Outputs are Moore (a function of state only). Exceptions:
  - imm_src decodes from opcode.
  - BEQ pc_write equals zero.
  - alu_control in EXECUTER/EXECUTEI decodes funct3/funct7_5.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10. Encodings 11-15 are unused; an unused code goes to FETCH on the next edge.
- Per-state outputs (any output not listed is 0):
  - FETCH: adr_src 0, ir_write 1, a 00, b 10, ADD, result_src 10, pc_write 1.
  - DECODE: a 01, b 01, ADD (branch target into ALUOut).
  - MEMADR: a 10, b 01, ADD.
  - MEMREAD: adr_src 1, result_src 00.
  - MEMWB: result_src 01, reg_write 1.
  - MEMWRITE: adr_src 1, result_src 00, mem_write 1.
  - EXECUTER: a 10, b 00, funct decode.
  - EXECUTEI: a 10, b 01, funct decode.
  - ALUWB: result_src 00, reg_write 1.
  - BEQ: a 10, b 00, SUB, result_src 00, pc_write = zero.
  - JAL: a 01, b 10, ADD, result_src 00, pc_write 1.
- Transitions:
  - FETCH -> DECODE.
  - DECODE by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; any other opcode -> FETCH (illegal instruction, no writes).
  - MEMADR -> MEMREAD if opcode is 0000011, else MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTER and EXECUTEI -> ALUWB -> FETCH.
  - JAL -> ALUWB.
  - BEQ -> FETCH.
- Instruction latency in clocks: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3.
- Funct decode:
  - funct3 000: SUB when EXECUTER and funct7_5 = 1, else ADD. I-type never subtracts.
  - funct3 111: AND.
  - funct3 110: OR.
  - funct3 010: see Optional Feature.
  - Any other funct3: ADD.
- imm_src by opcode: 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; any other opcode -> 00.

Optional Feature:
- Macro ALU_SLT_EN.
- Defined: funct3 010 in EXECUTER/EXECUTEI yields alu_control 0111 (set-less-than).
- Undefined: funct3 010 yields 0010 (ADD), and the code 0111 is never emitted.

Test Plan:
- rst_n low for 3 cycles, released mid-cycle -> state 0, all four write enables 0 during reset; first edge gives ir_write 1, pc_write 1, alu_control 0010, then state 1.
- opcode 0000011 (lw) -> states 0,1,2,3,4,0; reg_write 1 only in state 4 with result_src 01; adr_src 1 in state 3; imm_src 00.
- opcode 0110011 with funct3 000, funct7_5 1 -> EXECUTER alu_control 0110. Same instruction with funct3 111 -> 0000; with 110 -> 0001. Opcode 0010011 with funct3 000, funct7_5 1 -> 0010.
- opcode 1100011 (beq): zero = 1 -> BEQ state has pc_write 1 and alu_control 0110, back to FETCH after 3 clocks total; zero = 0 -> pc_write 0 in BEQ.
- opcode 0100011 (sw) -> states 0,1,2,5,0; mem_write 1 only in state 5, reg_write never 1, imm_src 01. Opcode 1111111 -> states 0,1,0 with no write enables after fetch.
- funct3 010 in EXECUTER -> 0111 with ALU_SLT_EN defined, 0010 without. Reset asserted in state 3 -> state 0 immediately, reg_write stays 0.
